cr_cmd_issue: RTL and testbench

//  Command issuer driving the correlator control-register decoder (cr_decode) from the host side.

---
 rtl/cr_cmd_issue.sv | 136 +++++++++++++
 tb/tb_cr_cmd_issue.sv | 149 ++++++++++++++
 2 files changed

// File: rtl/cr_cmd_issue.sv
// Host-side command issuer for cr_decode: queues legal opcodes in a small FIFO
// and emits paced single-cycle write strobes the decoder can follow.
module cr_cmd_issue #(
    parameter int DEPTH = 4,
    parameter int AW    = 2,
    parameter int GAP   = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cmd_valid,
    input  logic [3:0]  cmd_opcode,
    output logic        cmd_ready,
    output logic        we,
    output logic [3:0]  opcodeO,
    output logic        busy,
    output logic        err_illegal,
    output logic [15:0] issued_cnt
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_HOLD,
        S_GAP
    } state_t;

    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);
    localparam logic [3:0]  GAP_LAST = 4'(GAP - 1);

    state_t          state;
    logic [3:0]      fifo_mem [DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [AW:0]     count;
    logic [3:0]      gap_cnt;
    logic            full;
    logic            accept;
    logic            legal;
    logic            push;
    logic            pop;

    function automatic logic is_legal(input logic [3:0] op);
        case (op)
            4'd0, 4'd1, 4'd2, 4'd4, 4'd5, 4'd6, 4'd8: is_legal = 1'b1;
            default:                                  is_legal = 1'b0;
        endcase
    endfunction

    assign full      = (count == FULL_CNT);
    assign cmd_ready = ~full;
    assign accept    = cmd_valid & ~full;
    assign legal     = is_legal(cmd_opcode);
    assign push      = accept & legal;
    // Pops are only taken from IDLE, so a command pushed this cycle is never
    // visible to the FSM until the following cycle.
    assign pop       = (state == S_IDLE) && (count != '0);
    assign busy      = (count != '0) || (state != S_IDLE);

    // Queue storage carries no reset; validity is tracked by count.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr] <= cmd_opcode;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            err_illegal <= 1'b0;
        end else begin
            err_illegal <= accept & ~legal;
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

    // Issue sequencer: IDLE loads the head, ISSUE raises we for one cycle,
    // HOLD keeps opcodeO steady while the decoder samples it, GAP pads.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            we         <= 1'b0;
            opcodeO    <= 4'd0;
            issued_cnt <= 16'd0;
            gap_cnt    <= 4'd0;
        end else begin
            case (state)
                S_IDLE: begin
                    we <= 1'b0;
                    if (pop) begin
                        opcodeO <= fifo_mem[rd_ptr];
                        state   <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    we         <= 1'b1;
                    issued_cnt <= issued_cnt + 16'd1;
                    state      <= S_HOLD;
                end
                S_HOLD: begin
                    we      <= 1'b0;
                    gap_cnt <= 4'd0;
                    if (GAP == 0) begin
                        state <= S_IDLE;
                    end else begin
                        state <= S_GAP;
                    end
                end
                S_GAP: begin
                    we <= 1'b0;
                    if (gap_cnt == GAP_LAST) begin
                        state <= S_IDLE;
                    end else begin
                        gap_cnt <= gap_cnt + 4'd1;
                    end
                end
                default: begin
                    we    <= 1'b0;
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cr_cmd_issue.sv
// Randomized bench for cr_cmd_issue: two instances (GAP=0 and GAP=2) share the
// host stimulus and are compared every cycle against a timing-level model.
module tb_cr_cmd_issue;

    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_valid;
    logic [3:0]  cmd_opcode;

    logic        ready_o [2];
    logic        we_o    [2];
    logic [3:0]  op_o    [2];
    logic        busy_o  [2];
    logic        err_o   [2];
    logic [15:0] cnt_o   [2];

    int n_cmp = 0;
    int n_bad = 0;
    int k     = 0;

    // Model: queue contents, time of last pop and earliest next pop.
    int          qb   [2][16];
    int          qh   [2];
    int          qc   [2];
    int          lp   [2];
    int          np   [2];
    int          gp   [2] = '{0, 2};
    logic [3:0]  mop  [2];
    logic [15:0] mcnt [2];
    logic        merr [2];

    always #5 clk = ~clk;

    cr_cmd_issue #(.DEPTH(4), .AW(2), .GAP(0)) dut0 (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_opcode(cmd_opcode),
        .cmd_ready(ready_o[0]), .we(we_o[0]), .opcodeO(op_o[0]), .busy(busy_o[0]),
        .err_illegal(err_o[0]), .issued_cnt(cnt_o[0])
    );

    cr_cmd_issue #(.DEPTH(4), .AW(2), .GAP(2)) dut2 (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_opcode(cmd_opcode),
        .cmd_ready(ready_o[1]), .we(we_o[1]), .opcodeO(op_o[1]), .busy(busy_o[1]),
        .err_illegal(err_o[1]), .issued_cnt(cnt_o[1])
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s cycle=%0d got=%0h exp=%0h", tag, k, got, exp);
        end
    endtask

    // Advance the model by one clock edge for instance i.
    task automatic model_step(input int i, input logic v, input logic [3:0] op, input logic r);
        bit pre_full;
        if (r) begin
            qc[i] = 0; qh[i] = 0; lp[i] = -100; np[i] = 0;
            mop[i] = 4'd0; mcnt[i] = 16'd0; merr[i] = 1'b0;
            return;
        end
        merr[i]  = 1'b0;
        pre_full = (qc[i] == 4);
        if (k == lp[i] + 1) mcnt[i] = mcnt[i] + 16'd1;
        if (qc[i] > 0 && k >= np[i]) begin
            mop[i] = 4'(qb[i][qh[i]]);
            qh[i]  = (qh[i] + 1) % 16;
            qc[i]  = qc[i] - 1;
            lp[i]  = k;
            np[i]  = k + 3 + gp[i];
        end
        if (v && !pre_full) begin
            if (op inside {4'd0, 4'd1, 4'd2, 4'd4, 4'd5, 4'd6, 4'd8}) begin
                qb[i][(qh[i] + qc[i]) % 16] = int'(op);
                qc[i] = qc[i] + 1;
            end else begin
                merr[i] = 1'b1;
            end
        end
    endtask

    task automatic tick(input logic v, input logic [3:0] op, input logic r);
        cmd_valid  = v;
        cmd_opcode = op;
        rst        = r;
        @(posedge clk);
        k++;
        for (int i = 0; i < 2; i++) model_step(i, v, op, r);
        #1;
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("we[%0d]", i),          32'(we_o[i]),    32'(k == lp[i] + 1));
            chk($sformatf("opcodeO[%0d]", i),     32'(op_o[i]),    32'(mop[i]));
            chk($sformatf("issued_cnt[%0d]", i),  32'(cnt_o[i]),   32'(mcnt[i]));
            chk($sformatf("err_illegal[%0d]", i), 32'(err_o[i]),   32'(merr[i]));
            chk($sformatf("cmd_ready[%0d]", i),   32'(ready_o[i]), 32'(qc[i] < 4));
            chk($sformatf("busy[%0d]", i),        32'(busy_o[i]),
                32'((qc[i] > 0) || (k < lp[i] + 2 + gp[i])));
        end
    endtask

    task automatic idle(input int n);
        for (int j = 0; j < n; j++) tick(1'b0, 4'd0, 1'b0);
    endtask

    task automatic burst(input logic [3:0] ops [], input int settle);
        foreach (ops[j]) tick(1'b1, ops[j], 1'b0);
        idle(settle);
    endtask

    initial begin
        logic [3:0] s_start [];
        logic [3:0] s_four  [];
        logic [3:0] s_six   [];
        logic [3:0] s_bad   [];
        logic [3:0] s_gap   [];
        logic [3:0] s_rst   [];
        s_start = '{4'd1};
        s_four  = '{4'd1, 4'd4, 4'd5, 4'd8};
        s_six   = '{4'd1, 4'd2, 4'd4, 4'd5, 4'd6, 4'd8};
        s_bad   = '{4'd3, 4'd7, 4'd9, 4'hF};
        s_gap   = '{4'd0, 4'd2};
        s_rst   = '{4'd1, 4'd4, 4'd5, 4'd6};

        for (int j = 0; j < 3; j++) tick(1'b0, 4'd0, 1'b1);
        burst(s_start, 8);
        burst(s_four, 20);
        burst(s_six, 40);
        burst(s_bad, 6);
        burst(s_gap, 20);
        burst(s_rst, 1);
        tick(1'b0, 4'd0, 1'b1);
        idle(12);
        // Illegal opcode offered while full: held until space frees up.
        burst(s_four, 0);
        for (int j = 0; j < 6; j++) tick(1'b1, 4'd3, 1'b0);
        idle(40);

        for (int j = 0; j < 4000; j++) begin
            tick(($urandom_range(0, 99) < 55) ? 1'b1 : 1'b0,
                 4'($urandom_range(0, 15)),
                 ($urandom_range(0, 299) == 0) ? 1'b1 : 1'b0);
        end
        idle(40);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
